// File: rtl/qspi_fsm_arbiter_if.sv
// qspi_fsm_arbiter_if: bundles the two requester handshakes (command engine,
// XIP engine) and the sequencer-side start/done/abort signals of the
// qspi_fsm arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the requests and the done pulse.
interface qspi_fsm_arbiter_if #(
    parameter int unsigned CFG_W = 128
);
    // command engine side
    logic             cmd_req_i;
    logic [CFG_W-1:0] cmd_cfg_i;
    logic             cmd_gnt_o;
    logic             cmd_done_o;
    logic             cmd_err_o;
    // XIP engine side
    logic             xip_req_i;
    logic [CFG_W-1:0] xip_cfg_i;
    logic             xip_lock_i;
    logic             xip_gnt_o;
    logic             xip_done_o;
    logic             xip_err_o;
    // sequencer side
    logic             fsm_start_o;
    logic [CFG_W-1:0] fsm_cfg_o;
    logic             fsm_done_i;
    logic             fsm_abort_o;
    logic             busy_o;

    modport slave (
        input  cmd_req_i, cmd_cfg_i, xip_req_i, xip_cfg_i, xip_lock_i, fsm_done_i,
        output cmd_gnt_o, cmd_done_o, cmd_err_o, xip_gnt_o, xip_done_o, xip_err_o,
               fsm_start_o, fsm_cfg_o, fsm_abort_o, busy_o
    );

    modport master (
        output cmd_req_i, cmd_cfg_i, xip_req_i, xip_cfg_i, xip_lock_i, fsm_done_i,
        input  cmd_gnt_o, cmd_done_o, cmd_err_o, xip_gnt_o, xip_done_o, xip_err_o,
               fsm_start_o, fsm_cfg_o, fsm_abort_o, busy_o
    );
endinterface

// File: rtl/qspi_fsm_arbiter.sv
// qspi_fsm_arbiter: shares one qspi_fsm sequencer between the command engine
// and the XIP engine. Grants one requester, latches its config, issues a
// single start pulse, waits for done and routes it back to the owner. XIP has
// priority but may only win MAX_XIP_BURST times in a row while a command is
// pending; an XIP continuous-read lock keeps ownership between XIP requests.
// Optional watchdog abort of a hung transfer: define QSPI_ARB_WATCHDOG_EN.
module qspi_fsm_arbiter #(
    parameter int unsigned CFG_W          = 128,
    parameter int unsigned MAX_XIP_BURST  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    qspi_fsm_arbiter_if.slave     bus
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RELEASE   = 2'd3;

    localparam int unsigned BW = (MAX_XIP_BURST > 0) ? $clog2(MAX_XIP_BURST + 1) : 1;
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_XIP_BURST);

    logic [1:0]       state_q, state_d;
    logic             cmd_gnt_q, cmd_gnt_d;
    logic             xip_gnt_q, xip_gnt_d;
    logic             cmd_done_q, cmd_done_d;
    logic             xip_done_q, xip_done_d;
    logic             fsm_start_q, fsm_start_d;
    logic [CFG_W-1:0] fsm_cfg_q, fsm_cfg_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic             lock_q, lock_d;

    logic             pick_cmd;
    logic             pick_xip;

`ifdef QSPI_ARB_WATCHDOG_EN
    // wd_q counts WAIT_DONE cycles starting at 1, so the abort lands in cycle
    // TIMEOUT_CYCLES of the wait (TIMEOUT_CYCLES must be at least 2).
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0]  wd_q, wd_d;
    logic             abort_q, abort_d;
    logic             cmd_err_q, cmd_err_d;
    logic             xip_err_q, xip_err_d;
`endif

    // Command wins when the XIP burst limit is hit, or when it is alone and no
    // XIP lock is held; otherwise a requesting XIP engine wins.
    assign pick_cmd = bus.cmd_req_i &&
                      ((burst_q == BURST_LIM) || (!bus.xip_req_i && !lock_q));
    assign pick_xip = bus.xip_req_i && !pick_cmd;

    // Next-state and next-output logic for the arbitration sequence.
    always_comb begin
        state_d     = state_q;
        cmd_gnt_d   = cmd_gnt_q;
        xip_gnt_d   = xip_gnt_q;
        cmd_done_d  = 1'b0;
        xip_done_d  = 1'b0;
        fsm_start_d = 1'b0;
        fsm_cfg_d   = fsm_cfg_q;
        burst_d     = burst_q;
        lock_d      = lock_q;
`ifdef QSPI_ARB_WATCHDOG_EN
        wd_d        = wd_q;
        abort_d     = 1'b0;
        cmd_err_d   = 1'b0;
        xip_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_cmd) begin
                    cmd_gnt_d = 1'b1;
                    fsm_cfg_d = bus.cmd_cfg_i;
                    lock_d    = 1'b0;
                    state_d   = ST_START;
                end else if (pick_xip) begin
                    xip_gnt_d = 1'b1;
                    fsm_cfg_d = bus.xip_cfg_i;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                fsm_start_d = 1'b1;
                state_d     = ST_WAIT_DONE;
`ifdef QSPI_ARB_WATCHDOG_EN
                wd_d        = WD_W'(1);
`endif
            end
            ST_WAIT_DONE: begin
`ifdef QSPI_ARB_WATCHDOG_EN
                // Once the abort has gone out the transfer is finished as an
                // error even if a late done shows up.
                if (abort_q) begin
                    cmd_done_d = cmd_gnt_q;
                    xip_done_d = xip_gnt_q;
                    cmd_err_d  = cmd_gnt_q;
                    xip_err_d  = xip_gnt_q;
                    state_d    = ST_RELEASE;
                end else if (bus.fsm_done_i) begin
                    cmd_done_d = cmd_gnt_q;
                    xip_done_d = xip_gnt_q;
                    state_d    = ST_RELEASE;
                end else if (wd_q == WD_LIM) begin
                    abort_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`else
                if (bus.fsm_done_i) begin
                    cmd_done_d = cmd_gnt_q;
                    xip_done_d = xip_gnt_q;
                    state_d    = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                cmd_gnt_d = 1'b0;
                xip_gnt_d = 1'b0;
                if (xip_gnt_q && bus.cmd_req_i) begin
                    burst_d = (burst_q == BURST_LIM) ? BURST_LIM : burst_q + BW'(1);
                end else begin
                    burst_d = '0;
                end
`ifdef QSPI_ARB_WATCHDOG_EN
                lock_d = xip_gnt_q && bus.xip_lock_i && !xip_err_q;
`else
                lock_d = xip_gnt_q && bus.xip_lock_i;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_gnt_q   <= 1'b0;
            xip_gnt_q   <= 1'b0;
            cmd_done_q  <= 1'b0;
            xip_done_q  <= 1'b0;
            fsm_start_q <= 1'b0;
            fsm_cfg_q   <= '0;
            burst_q     <= '0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_gnt_q   <= cmd_gnt_d;
            xip_gnt_q   <= xip_gnt_d;
            cmd_done_q  <= cmd_done_d;
            xip_done_q  <= xip_done_d;
            fsm_start_q <= fsm_start_d;
            fsm_cfg_q   <= fsm_cfg_d;
            burst_q     <= burst_d;
            lock_q      <= lock_d;
        end
    end

`ifdef QSPI_ARB_WATCHDOG_EN
    // Watchdog counter, abort pulse and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q      <= '0;
            abort_q   <= 1'b0;
            cmd_err_q <= 1'b0;
            xip_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            abort_q   <= abort_d;
            cmd_err_q <= cmd_err_d;
            xip_err_q <= xip_err_d;
        end
    end

    assign bus.fsm_abort_o = abort_q;
    assign bus.cmd_err_o   = cmd_err_q;
    assign bus.xip_err_o   = xip_err_q;
`else
    assign bus.fsm_abort_o = 1'b0;
    assign bus.cmd_err_o   = 1'b0;
    assign bus.xip_err_o   = 1'b0;
`endif

    assign bus.cmd_gnt_o   = cmd_gnt_q;
    assign bus.xip_gnt_o   = xip_gnt_q;
    assign bus.cmd_done_o  = cmd_done_q;
    assign bus.xip_done_o  = xip_done_q;
    assign bus.fsm_start_o = fsm_start_q;
    assign bus.fsm_cfg_o   = fsm_cfg_q;
    assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qspi_fsm_arbiter.sv
// tb_qspi_fsm_arbiter: directed stimulus for qspi_fsm_arbiter. A transaction
// level model (owner, cycles since grant, done arrival, XIP run length, lock)
// predicts every output each cycle; directed literal checks pin the model.
module tb_qspi_fsm_arbiter;

    localparam int unsigned CFG_W     = 128;
    localparam int          MAX_BURST = 4;
`ifdef QSPI_ARB_WATCHDOG_EN
    localparam int          TO = 64;
    localparam bit          WD = 1'b1;
`else
    localparam int          TO = 4096;
    localparam bit          WD = 1'b0;
`endif

    typedef logic [127:0] w_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    qspi_fsm_arbiter_if #(.CFG_W(CFG_W)) bus();

    qspi_fsm_arbiter #(
        .CFG_W          (CFG_W),
        .MAX_XIP_BURST  (MAX_BURST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: owner 0 none / 1 cmd / 2 xip, age = cycles since grant,
    // fin = age at which the done pulse is visible (0 = not yet)
    int               m_owner = 0;
    int               m_age   = 0;
    int               m_fin   = 0;
    int               m_run   = 0;
    bit               m_err   = 1'b0;
    bit               m_lock  = 1'b0;
    logic [CFG_W-1:0] m_cfg   = '0;

    task automatic chk(input string name, input w_t act, input w_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_owner = 0; m_age = 0; m_fin = 0; m_run = 0;
            m_err = 1'b0; m_lock = 1'b0; m_cfg = '0;
        end else if (m_owner == 0) begin
            if (bus.cmd_req_i && m_run == MAX_BURST) begin
                m_owner = 1;
                m_lock  = 1'b0;
            end else if (bus.xip_req_i) begin
                m_owner = 2;
            end else if (bus.cmd_req_i && !m_lock) begin
                m_owner = 1;
            end
            if (m_owner != 0) begin
                m_age = 0; m_fin = 0; m_err = 1'b0;
                m_cfg = (m_owner == 1) ? bus.cmd_cfg_i : bus.xip_cfg_i;
            end
        end else begin
            m_age++;
            if (m_fin == 0) begin
                if (m_age >= 2 && bus.fsm_done_i && (!WD || m_age <= TO)) begin
                    m_fin = m_age;
                end else if (WD && m_age == TO + 1) begin
                    m_fin = m_age;
                    m_err = 1'b1;
                end
            end else begin
                if (m_owner == 2 && bus.cmd_req_i)
                    m_run = (m_run + 1 > MAX_BURST) ? MAX_BURST : m_run + 1;
                else
                    m_run = 0;
                m_lock  = (m_owner == 2) && bus.xip_lock_i && !m_err;
                m_owner = 0;
                m_err   = 1'b0;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [8:0] act;
        logic [8:0] exp;
        logic       dn;
        dn  = (m_owner != 0) && (m_fin != 0) && (m_age == m_fin);
        act = {bus.cmd_gnt_o, bus.cmd_done_o, bus.cmd_err_o,
               bus.xip_gnt_o, bus.xip_done_o, bus.xip_err_o,
               bus.fsm_start_o, bus.fsm_abort_o, bus.busy_o};
        exp = {m_owner == 1, dn && m_owner == 1, dn && m_err && m_owner == 1,
               m_owner == 2, dn && m_owner == 2, dn && m_err && m_owner == 2,
               m_owner != 0 && m_age == 1,
               WD && m_owner != 0 && m_fin == 0 && m_age == TO,
               m_owner != 0};
        chk("outputs", w_t'(act), w_t'(exp));
        chk("fsm_cfg", w_t'(bus.fsm_cfg_o), w_t'(m_cfg));
    endtask

    // one clock: model sees the same inputs as the DUT at the edge, outputs
    // are compared and new inputs driven at the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        bus.cmd_req_i  = 1'b0;
        bus.xip_req_i  = 1'b0;
        bus.xip_lock_i = 1'b0;
        bus.fsm_done_i = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        while (!bus.fsm_start_o && n < 32) begin
            tick();
            n++;
        end
        ok = bus.fsm_start_o;
        if (!ok) chk("start_seen", w_t'(bus.fsm_start_o), w_t'(1));
    endtask

    // one transfer: wait for start, answer with done after lat cycles, then
    // drop the owner's request (XIP optionally keeps requesting)
    task automatic serve(input int lat, input bit keep_xip, output int who);
        bit ok;
        who = 0;
        wait_start(ok);
        if (!ok) return;
        repeat (lat) tick();
        bus.fsm_done_i = 1'b1;
        tick();
        bus.fsm_done_i = 1'b0;
        if (bus.cmd_done_o) begin
            who = 1;
            bus.cmd_req_i = 1'b0;
        end else if (bus.xip_done_o) begin
            who = 2;
            if (!keep_xip) bus.xip_req_i = 1'b0;
        end
    endtask

    initial begin
        int who;
        int cnt;
        bit ok;
        bus.cmd_req_i  = 1'b0;
        bus.xip_req_i  = 1'b0;
        bus.xip_lock_i = 1'b0;
        bus.fsm_done_i = 1'b0;
        bus.cmd_cfg_i  = '0;
        bus.xip_cfg_i  = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_outputs", w_t'({bus.cmd_gnt_o, bus.cmd_done_o, bus.xip_gnt_o,
                                   bus.xip_done_o, bus.fsm_start_o, bus.busy_o}), w_t'(0));
        chk("reset_cfg", w_t'(bus.fsm_cfg_o), w_t'(0));

        // single command transfer, cfg changed and req dropped after latch
        bus.cmd_cfg_i = {32{4'hA}} ^ {16{8'h0F}};
        bus.cmd_req_i = 1'b1;
        tick();
        chk("t1_gnt", w_t'(bus.cmd_gnt_o), w_t'(1));
        chk("t1_no_early_start", w_t'(bus.fsm_start_o), w_t'(0));
        tick();
        chk("t1_start_2cyc", w_t'(bus.fsm_start_o), w_t'(1));
        chk("t1_cfg", w_t'(bus.fsm_cfg_o), {16{8'hA5}});
        bus.cmd_cfg_i = '1;
        bus.cmd_req_i = 1'b0;
        tick();
        chk("t1_start_1cyc", w_t'(bus.fsm_start_o), w_t'(0));
        repeat (18) tick();
        bus.fsm_done_i = 1'b1;
        tick();
        bus.fsm_done_i = 1'b0;
        chk("t1_cmd_done", w_t'(bus.cmd_done_o), w_t'(1));
        chk("t1_xip_quiet", w_t'({bus.xip_gnt_o, bus.xip_done_o}), w_t'(0));
        chk("t1_cfg_held", w_t'(bus.fsm_cfg_o), {16{8'hA5}});
        tick();
        chk("t1_release", w_t'({bus.cmd_gnt_o, bus.cmd_done_o, bus.busy_o}), w_t'(0));
        bus.fsm_done_i = 1'b1;
        tick();
        bus.fsm_done_i = 1'b0;
        chk("stray_done", w_t'({bus.cmd_done_o, bus.xip_done_o, bus.busy_o}), w_t'(0));

        // simultaneous requests: XIP first, then command
        bus.cmd_cfg_i = 128'h1111;
        bus.xip_cfg_i = 128'h2222;
        bus.cmd_req_i = 1'b1;
        bus.xip_req_i = 1'b1;
        serve(3, 1'b0, who);
        chk("t2_xip_first", w_t'(who), w_t'(2));
        serve(3, 1'b0, who);
        chk("t2_cmd_second", w_t'(who), w_t'(1));
        tick();

        // XIP burst limit with command pending, without and with lock
        for (int l = 0; l < 2; l++) begin
            do_reset();
            bus.xip_lock_i = l[0];
            bus.cmd_req_i  = 1'b1;
            bus.xip_req_i  = 1'b1;
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                serve(2, 1'b1, who);
                if (who != 2) break;
                cnt++;
            end
            chk("t3_xip_burst", w_t'(cnt), w_t'(4));
            chk("t3_cmd_wins", w_t'(who), w_t'(1));
            serve(2, 1'b0, who);
            chk("t3_xip_after_cmd", w_t'(who), w_t'(2));
            bus.xip_lock_i = 1'b0;
            tick();
        end

        // lock holds off a pending command until XIP releases it
        do_reset();
        bus.cmd_req_i  = 1'b1;
        bus.xip_req_i  = 1'b1;
        bus.xip_lock_i = 1'b1;
        serve(2, 1'b0, who);
        chk("t4_xip_locks", w_t'(who), w_t'(2));
        repeat (3) tick();
        chk("t4_cmd_held_off", w_t'({bus.cmd_gnt_o, bus.busy_o}), w_t'(0));
        bus.xip_req_i  = 1'b1;
        bus.xip_lock_i = 1'b0;
        serve(2, 1'b0, who);
        chk("t4_xip_again", w_t'(who), w_t'(2));
        serve(2, 1'b0, who);
        chk("t4_cmd_after_unlock", w_t'(who), w_t'(1));
        tick();

        // reset in the middle of a transfer
        do_reset();
        bus.cmd_req_i = 1'b1;
        wait_start(ok);
        repeat (3) tick();
        bus.cmd_req_i = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_reset_clears", w_t'({bus.cmd_gnt_o, bus.cmd_done_o, bus.fsm_start_o,
                                     bus.busy_o}), w_t'(0));
        tick();
        bus.fsm_done_i = 1'b1;
        tick();
        bus.fsm_done_i = 1'b0;
        chk("t5_no_done", w_t'({bus.cmd_done_o, bus.xip_done_o}), w_t'(0));

        // sequencer never answers
        do_reset();
        bus.xip_req_i = 1'b1;
        wait_start(ok);
`ifdef QSPI_ARB_WATCHDOG_EN
        cnt = 0;
        while (!bus.fsm_abort_o && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("t6_abort_cycle", w_t'(cnt), w_t'(TO - 1));
        tick();
        chk("t6_done_err", w_t'({bus.xip_done_o, bus.xip_err_o}), w_t'(3));
        bus.xip_req_i = 1'b0;
        tick();
        chk("t6_idle", w_t'(bus.busy_o), w_t'(0));
`else
        repeat (100) tick();
        chk("t6_still_busy", w_t'(bus.busy_o), w_t'(1));
        chk("t6_no_abort", w_t'(bus.fsm_abort_o), w_t'(0));
`endif
        do_reset();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
